// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with pointer-wrap full/empty detection, threshold flags and
// selectable registered-read or first-word-fall-through output.
module sync_fifo_buffer #(
    parameter int DATA_WIDTH         = 8,
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter int FWFT               = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       read_enable,
    output logic [DATA_WIDTH-1:0]      read_data,
    output logic                       read_valid,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);
    localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         write_pointer;
    logic [PW-1:0]         read_pointer;
    logic                  push_ok;
    logic                  pop_ok;

    // Acceptance uses the registered flags, so a push at full is refused even
    // when a pop frees a slot on the same edge.
    assign push_ok = write_enable && !fifo_full;
    assign pop_ok  = read_enable && !fifo_empty;

    assign fifo_empty   = (write_pointer == read_pointer);
    assign fifo_full    = (write_pointer[AW] != read_pointer[AW]) &&
                          (write_pointer[AW-1:0] == read_pointer[AW-1:0]);
    assign almost_full  = (fill_level >= AF_LEVEL);
    assign almost_empty = (fill_level <= AE_LEVEL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            fill_level    <= '0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            overflow  <= write_enable && !push_ok;
            underflow <= read_enable && !pop_ok;
            if (push_ok)
                write_pointer <= write_pointer + PW'(1);
            if (pop_ok)
                read_pointer <= read_pointer + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   fill_level <= fill_level + PW'(1);
                2'b01:   fill_level <= fill_level - PW'(1);
                default: fill_level <= fill_level;
            endcase
        end
    end

    // Storage is deliberately not reset; the pointers alone define valid data.
    always_ff @(posedge clock) begin
        if (push_ok)
            mem[write_pointer[AW-1:0]] <= write_data;
    end

    generate
        if (FWFT == 0) begin : g_registered_read
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    read_data  <= '0;
                    read_valid <= 1'b0;
                end else begin
                    read_valid <= pop_ok;
                    if (pop_ok)
                        read_data <= mem[read_pointer[AW-1:0]];
                end
            end
        end else begin : g_fall_through
            assign read_data  = mem[read_pointer[AW-1:0]];
            assign read_valid = !fifo_empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Directed bench for sync_fifo_buffer: a vector table for the fill/drain and
// collision cases, plus sequences for wrap-around, async reset and FWFT.
module tb_sync_fifo_buffer;

    logic       clock = 1'b0;
    logic       reset;
    logic       write_enable, read_enable;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       read_valid, fifo_full, fifo_empty, almost_full, almost_empty;
    logic [4:0] fill_level;
    logic       overflow, underflow;

    logic       f_we, f_re;
    logic [7:0] f_wd, f_rd;
    logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] f_fill;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    sync_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
        .clock(clock), .reset(reset),
        .write_enable(write_enable), .write_data(write_data),
        .read_enable(read_enable), .read_data(read_data), .read_valid(read_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .fill_level(fill_level), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) dut_fwft (
        .clock(clock), .reset(reset),
        .write_enable(f_we), .write_data(f_wd),
        .read_enable(f_re), .read_data(f_rd), .read_valid(f_rv),
        .fifo_full(f_full), .fifo_empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae),
        .fill_level(f_fill), .overflow(f_ovf), .underflow(f_udf)
    );

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic [4:0] fill;
        logic [3:0] flags;   // {full, empty, almost_full, almost_empty}
        logic       ovf;
        logic       udf;
        logic       rv;
        logic [7:0] rd;
        logic       chk_rd;
    } vec_t;

    vec_t vecs [0:127];
    int   n_vecs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic we, input logic [7:0] wd, input logic re,
                           input int lvl, input logic ovf, input logic udf,
                           input logic rv, input logic [7:0] rd, input logic chk_rd);
        vec_t v;
        v.we = we; v.wd = wd; v.re = re;
        v.fill  = lvl[4:0];
        v.flags = {lvl == 16, lvl == 0, lvl >= 14, lvl <= 2};
        v.ovf = ovf; v.udf = udf; v.rv = rv; v.rd = rd; v.chk_rd = chk_rd;
        vecs[n_vecs] = v;
        n_vecs++;
    endtask

    task automatic step(input logic we, input logic [7:0] wd, input logic re);
        @(negedge clock);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        @(posedge clock);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    task automatic f_step(input logic we, input logic [7:0] wd, input logic re);
        @(negedge clock);
        f_we = we;
        f_wd = wd;
        f_re = re;
        @(posedge clock);
        #1;
        f_we = 1'b0;
        f_re = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " fill"},  32'(fill_level), 32'd0);
        check({tag, " flags"}, 32'({fifo_full, fifo_empty, almost_full, almost_empty}), 32'b0101);
        check({tag, " rv"},    32'(read_valid), 32'd0);
        check({tag, " ovf"},   32'(overflow), 32'd0);
        check({tag, " udf"},   32'(underflow), 32'd0);
        check({tag, " rd"},    32'(read_data), 32'd0);
    endtask

    initial begin
        byte unsigned q[$];
        int pushes, pops;
        logic we, re, acc_push, acc_pop;
        logic [7:0] exp_rd;

        reset = 1'b1;
        write_enable = 1'b0; read_enable = 1'b0; write_data = '0;
        f_we = 1'b0; f_re = 1'b0; f_wd = '0;

        // Vector table: fill, overflow, drain, underflow, full and empty collisions.
        for (int i = 0; i < 16; i++) add_vec(1, 8'(i), 0, i + 1, 0, 0, 0, 8'h00, 0);
        add_vec(1, 8'hFF, 0, 16, 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) add_vec(0, 8'h00, 1, 15 - i, 0, 0, 1, 8'(i), 1);
        add_vec(0, 8'h00, 1, 0, 0, 1, 0, 8'h0F, 1);
        for (int i = 0; i < 16; i++) add_vec(1, 8'(8'h20 + i), 0, i + 1, 0, 0, 0, 8'h00, 0);
        add_vec(1, 8'hEE, 1, 15, 1, 0, 1, 8'h20, 1);
        for (int i = 1; i < 16; i++) add_vec(0, 8'h00, 1, 15 - i, 0, 0, 1, 8'(8'h20 + i), 1);
        add_vec(1, 8'h55, 1, 1, 0, 1, 0, 8'h2F, 1);
        add_vec(0, 8'h00, 1, 0, 0, 0, 1, 8'h55, 1);

        #3;
        check_reset_state("reset");
        #9 reset = 1'b0;

        for (int i = 0; i < n_vecs; i++) begin
            step(vecs[i].we, vecs[i].wd, vecs[i].re);
            check($sformatf("v%0d fill", i),  32'(fill_level), 32'(vecs[i].fill));
            check($sformatf("v%0d flags", i),
                  32'({fifo_full, fifo_empty, almost_full, almost_empty}), 32'(vecs[i].flags));
            check($sformatf("v%0d ovf", i), 32'(overflow),   32'(vecs[i].ovf));
            check($sformatf("v%0d udf", i), 32'(underflow),  32'(vecs[i].udf));
            check($sformatf("v%0d rv", i),  32'(read_valid), 32'(vecs[i].rv));
            if (vecs[i].chk_rd)
                check($sformatf("v%0d rd", i), 32'(read_data), 32'(vecs[i].rd));
        end

        // Interleaved traffic across pointer wrap against a queue model.
        pushes = 0; pops = 0;
        for (int k = 0; k < 120 && (pushes < 40 || pops < 40); k++) begin
            we = (pushes < 40) && ((k % 3 != 0) || (k < 8));
            re = (pops < 40) && (k >= 4) && ((k % 2 == 0) || (pushes == 40));
            acc_push = we && (q.size() < 16);
            acc_pop  = re && (q.size() > 0);
            exp_rd   = acc_pop ? q[0] : 8'h00;
            step(we, 8'(8'h80 + pushes), re);
            if (acc_pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (acc_push) begin
                q.push_back(8'(8'h80 + pushes));
                pushes++;
            end
            check($sformatf("wrap%0d fill", k), 32'(fill_level), 32'(q.size()));
            check($sformatf("wrap%0d rv", k),   32'(read_valid), 32'(acc_pop));
            check($sformatf("wrap%0d ovf", k),  32'(overflow),   32'(we && !acc_push));
            if (acc_pop)
                check($sformatf("wrap%0d rd", k), 32'(read_data), 32'(exp_rd));
        end
        check("wrap pushes", 32'(pushes), 32'd40);
        check("wrap pops",   32'(pops),   32'd40);

        // Async reset at fill_level 7 with a read in flight.
        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0);
        check("pre-reset fill8", 32'(fill_level), 32'd8);
        step(0, 8'h00, 1);
        check("pre-reset fill7", 32'(fill_level), 32'd7);
        check("pre-reset rd",    32'(read_data),  32'h10);
        #2 reset = 1'b1;
        #1;
        check_reset_state("async reset");
        @(negedge clock);
        reset = 1'b0;
        step(1, 8'hC3, 0);
        check("post-reset fill", 32'(fill_level), 32'd1);
        step(0, 8'h00, 1);
        check("post-reset rd",    32'(read_data),  32'hC3);
        check("post-reset rv",    32'(read_valid), 32'd1);
        check("post-reset empty", 32'(fifo_empty), 32'd1);

        // First-word-fall-through instance.
        check("fwft idle rv", 32'(f_rv), 32'd0);
        f_step(1, 8'hA5, 0);
        check("fwft head",     32'(f_rd), 32'hA5);
        check("fwft rv",       32'(f_rv), 32'd1);
        f_step(0, 8'h00, 0);
        check("fwft hold",     32'(f_rd), 32'hA5);
        f_step(1, 8'h3C, 0);
        check("fwft head2",    32'(f_rd), 32'hA5);
        check("fwft fill2",    32'(f_fill), 32'd2);
        f_step(0, 8'h00, 1);
        check("fwft next head", 32'(f_rd), 32'h3C);
        check("fwft fill1",    32'(f_fill), 32'd1);
        f_step(0, 8'h00, 1);
        check("fwft drained rv", 32'(f_rv), 32'd0);
        f_step(0, 8'h00, 1);
        check("fwft udf",      32'(f_udf), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_buffer.md
SYNC_FIFO_BUFFER -- requirements
Module: sync_fifo_buffer

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, number of words; must be a power of two, at least 2.
REQ-003 SHALL provide parameter ALMOST_FULL_LEVEL, default DEPTH-2; almost_full asserts when fill_level is at least this value.
REQ-004 SHALL provide parameter ALMOST_EMPTY_LEVEL, default 2; almost_empty asserts when fill_level is at most this value.
REQ-005 SHALL provide parameter FWFT, default 0; 0 selects registered-read mode, 1 selects first-word-fall-through mode.
REQ-006 SHALL provide the following ports:
- clock, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-high.
- write_enable, input, 1, push request.
- write_data, input, DATA_WIDTH, word to push.
- read_enable, input, 1, pop request.
- read_data, output, DATA_WIDTH, popped word (FWFT=0) or head word (FWFT=1).
- read_valid, output, 1, read_data is valid.
- fifo_full, output, 1, fill_level == DEPTH.
- fifo_empty, output, 1, fill_level == 0.
- almost_full, output, 1, threshold flag.
- almost_empty, output, 1, threshold flag.
- fill_level, output, $clog2(DEPTH)+1, words stored.
- overflow, output, 1, one-cycle pulse on a rejected push.
- underflow, output, 1, one-cycle pulse on a rejected pop.

Function
REQ-007 SHALL store words in a DEPTH-entry register array, indexed by write and read pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
REQ-008 SHALL accept a push when write_enable=1 and fifo_full=0 (pre-edge value): store write_data at write_pointer and increment the pointer modulo 2*DEPTH.
REQ-009 SHALL accept a pop when read_enable=1 and fifo_empty=0 (pre-edge value): increment read_pointer modulo 2*DEPTH.
REQ-010 SHALL, for simultaneous accepted push and pop, perform both and leave fill_level unchanged; at full, a push is rejected even when a pop is accepted in the same cycle.
REQ-011 SHALL, for a push into an empty FIFO with a pop in the same cycle, accept the push only; pulse underflow.
REQ-012 SHALL update fill_level as registered state: +1 on push only, -1 on pop only, unchanged otherwise; never above DEPTH, never below 0.
REQ-013 SHALL derive fifo_full, fifo_empty, almost_full and almost_empty combinationally from registered pointer/fill state; they are valid in the cycle after the causing edge.
REQ-014 SHALL, when FWFT=0, register read_data with the word at read_pointer on an accepted pop, set read_valid=1 for exactly the following cycle, and otherwise hold read_data with read_valid=0; latency is 1 cycle.
REQ-015 SHALL, when FWFT=1, drive read_data with the head word and read_valid=!fifo_empty; read_enable acknowledges the head; the next head appears the cycle after the pop; a word written into an empty FIFO appears one cycle after the write edge.
REQ-016 SHALL register overflow=1 for one cycle after a rejected push and underflow=1 for one cycle after a rejected pop; rejected operations alter no other state.
REQ-017 SHALL handle pointer wrap-around transparently: full when the pointers differ only in the MSB, empty when the pointers are equal.

Reset
REQ-018 SHALL, while reset=1, immediately force both pointers=0, fill_level=0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0, read_valid=0, overflow=0, underflow=0 and read_data=0 (FWFT=0).
REQ-019 SHALL not clear array contents on reset; a reset asserted mid-operation discards all stored words and in-flight reads.

Verification
REQ-020 SHALL cover (defaults, FWFT=0): 16 pushes of 0x00..0x0F -> fifo_full=1, fill_level=16, almost_full from level 14; a 17th push -> overflow pulse, fill_level stays 16.
REQ-021 SHALL cover: from full, 16 pops -> read_data 0x00..0x0F in order, each one cycle after its pop with read_valid=1, then fifo_empty=1; a 17th pop -> underflow pulse.
REQ-022 SHALL cover: 40 pushes interleaved with 40 pops across pointer wrap -> data order preserved, fill_level never exceeds 16.
REQ-023 SHALL cover: at fill_level=16, simultaneous push and pop -> pop accepted, push rejected with overflow, fill_level=15; at fill_level=0, simultaneous push and pop -> fill_level=1, underflow pulse.
REQ-024 SHALL cover: FWFT=1, push 0xA5 into empty -> read_data=0xA5, read_valid=1 next cycle with no read_enable.
REQ-025 SHALL cover: reset asserted asynchronously at fill_level=7 -> all flags and counters at reset values before the next clock edge; a subsequent push/pop returns the new data only.
